// File: rtl/rs544522_cw_assembler_lal8.sv
// Purpose: turns the front-padded 8-lane RS(544,522) message stream plus encoder parity into 68 full codeword beats.
// Latency: data beat k appears 1 cycle after input beat k+1; tail beats 65..67 appear 1..3 cycles after parity_valid_i.
// Backpressure: none; input gaps stall the output one for one, and protocol violations drop or ignore beats with an err_o pulse.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/valid_i/last_i/s_blk_i padded message beats;
//        parity_valid_i/parity_i parity strobe and symbols (index i = coefficient of x^i);
//        cw_valid_o/cw_sop_o/cw_eop_o/cw_blk_o codeword beats (lane 0 = highest degree); err_o protocol-error pulse.
module rs544522_cw_assembler_lal8 #(
  parameter int W  = 10,
  parameter int L  = 8,
  parameter int K  = 522,
  parameter int R  = 22,
  parameter int ZP = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         valid_i,
  input  logic         last_i,
  input  logic [W-1:0] s_blk_i [0:L-1],
  input  logic         parity_valid_i,
  input  logic [W-1:0] parity_i [0:R-1],
  output logic         cw_valid_o,
  output logic         cw_sop_o,
  output logic         cw_eop_o,
  output logic [W-1:0] cw_blk_o [0:L-1],
  output logic         err_o
);

  localparam int NB = (K + ZP) / L;  // input beats per frame (66)
  localparam int HL = L - ZP;        // lanes carried over from the previous beat (2)
  localparam int CW = 7;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT_PAR, S_T1, S_T2} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_hold [0:HL-1];
  logic [W-1:0]  r_par  [0:R-1];
  logic          r_cw_vld, r_sop, r_eop, r_err;
  logic [W-1:0]  r_blk  [0:L-1];

  logic          w_start, w_last_beat, w_begin, w_err;
  logic [W-1:0]  w_data_blk [0:L-1];
  logic [W-1:0]  w_tail0    [0:L-1];
  logic [W-1:0]  w_tail1    [0:L-1];
  logic [W-1:0]  w_tail2    [0:L-1];

  assign w_start     = valid_i & start_i;
  assign w_last_beat = (r_cnt == CW'(NB - 1));
  // a start beat that also claims to be last can never be beat 65, so it is dropped
  assign w_begin     = w_start & ~last_i;

  // Realignment: previous beat's top HL lanes followed by the first ZP lanes of this beat.
  always_comb begin
    for (int j = 0; j < HL; j++) begin
      w_data_blk[j] = r_hold[j];
      w_tail0[j]    = r_hold[j];
    end
    for (int j = HL; j < L; j++) begin
      w_data_blk[j] = s_blk_i[j-HL];
      w_tail0[j]    = parity_i[R-1-(j-HL)];
    end
    for (int j = 0; j < L; j++) begin
      w_tail1[j] = r_par[R-1-ZP-j];
      w_tail2[j] = r_par[R-1-ZP-L-j];
    end
  end

  always_comb begin
    w_err = 1'b0;
    case (r_state)
      S_IDLE, S_T2: w_err = (valid_i & ~start_i) | (w_start & last_i);
      S_DATA:       w_err = w_start | (valid_i & (last_i != w_last_beat));
      S_WAIT_PAR,
      S_T1:         w_err = w_start;
      default:      w_err = 1'b0;
    endcase
    if (parity_valid_i && r_state != S_WAIT_PAR) w_err = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cw_vld <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_err    <= 1'b0;
      for (int j = 0; j < HL; j++) r_hold[j] <= '0;
      for (int j = 0; j < R;  j++) r_par[j]  <= '0;
      for (int j = 0; j < L;  j++) r_blk[j]  <= '0;
    end else begin
      r_cw_vld <= 1'b0;
      r_err    <= w_err;
      case (r_state)
        S_IDLE: begin
          if (w_begin) begin
            for (int j = 0; j < HL; j++) r_hold[j] <= s_blk_i[ZP+j];
            r_cnt   <= CW'(1);
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_start) begin
            // restart: partial frame is abandoned without eop
            r_cnt   <= w_begin ? CW'(1) : '0;
            r_state <= w_begin ? S_DATA : S_IDLE;
            for (int j = 0; j < HL; j++) r_hold[j] <= s_blk_i[ZP+j];
          end else if (valid_i) begin
            if (last_i != w_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_blk    <= w_data_blk;
              r_cw_vld <= 1'b1;
              r_sop    <= (r_cnt == CW'(1));
              r_eop    <= 1'b0;
              for (int j = 0; j < HL; j++) r_hold[j] <= s_blk_i[ZP+j];
              if (last_i) begin
                r_cnt   <= '0;
                r_state <= S_WAIT_PAR;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
        end
        S_WAIT_PAR: begin
          if (parity_valid_i) begin
            r_par    <= parity_i;
            r_blk    <= w_tail0;
            r_cw_vld <= 1'b1;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_state  <= S_T1;
          end
        end
        S_T1: begin
          r_blk    <= w_tail1;
          r_cw_vld <= 1'b1;
          r_sop    <= 1'b0;
          r_eop    <= 1'b0;
          r_state  <= S_T2;
        end
        S_T2: begin
          r_blk    <= w_tail2;
          r_cw_vld <= 1'b1;
          r_sop    <= 1'b0;
          r_eop    <= 1'b1;
          if (w_begin) begin
            for (int j = 0; j < HL; j++) r_hold[j] <= s_blk_i[ZP+j];
            r_cnt   <= CW'(1);
            r_state <= S_DATA;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cw_valid_o = r_cw_vld;
  assign cw_sop_o   = r_sop;
  assign cw_eop_o   = r_eop;
  assign cw_blk_o   = r_blk;
  assign err_o      = r_err;

endmodule

// File: tb/tb_rs544522_cw_assembler_lal8.sv
module tb_rs544522_cw_assembler_lal8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, valid, last, pv;
  logic [9:0] s_blk   [0:7];
  logic [9:0] par_in  [0:21];
  logic       cw_valid, cw_sop, cw_eop, err;
  logic [9:0] cw_blk  [0:7];

  always #5 clk = ~clk;

  rs544522_cw_assembler_lal8 dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid), .last_i(last),
    .s_blk_i(s_blk), .parity_valid_i(pv), .parity_i(par_in),
    .cw_valid_o(cw_valid), .cw_sop_o(cw_sop), .cw_eop_o(cw_eop), .cw_blk_o(cw_blk), .err_o(err)
  );

  typedef struct packed {
    logic [7:0][9:0] blk;
    logic            sop;
    logic            eop;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, failures = 0;
  int         err_cnt = 0, vld_cnt = 0, sop_cnt = 0, eop_cnt = 0;
  int         cyc = 0, eop_cyc = 0, sop_gap = 0, idx = 0;
  bit         chk_en = 1'b0;
  logic [9:0] ext [0:527];
  logic [9:0] par [0:21];
  logic [9:0] g   [0:22];
  logic [9:0] rem [0:21];
  logic [9:0] cap [0:67][0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] r = '0;
    logic [9:0] aa = a;
    for (int i = 0; i < 10; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[8:0], 1'b0} ^ (aa[9] ? 10'h009 : 10'h000);
    end
    return r;
  endfunction

  // codeword symbol n, highest degree first: message then parity x^21..x^0
  function automatic logic [9:0] cw_sym(input int n);
    return (n < 522) ? ext[n+6] : par[543-n];
  endfunction

  task automatic push_cw(input int k);
    exp_t e;
    for (int j = 0; j < 8; j++) e.blk[j] = cw_sym(8*k + j);
    e.sop = (k == 0);
    e.eop = (k == 67);
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    valid = 1'b0; start = 1'b0; last = 1'b0; pv = 1'b0;
  endtask

  task automatic fill_a;
    for (int p = 0; p < 528; p++) ext[p] = (p < 6) ? 10'd0 : 10'(527 - p);
    for (int i = 0; i < 22; i++) par[i] = 10'(12'h300 + i);
  endtask

  task automatic fill_rand;
    logic [9:0] r [0:21];
    logic [9:0] fb;
    for (int p = 0; p < 528; p++) ext[p] = (p < 6) ? 10'd0 : 10'($urandom_range(0, 1023));
    for (int i = 0; i < 22; i++) r[i] = '0;
    for (int p = 6; p < 528; p++) begin
      fb = ext[p] ^ r[21];
      for (int i = 21; i > 0; i--) r[i] = r[i-1] ^ gf_mul(fb, g[i]);
      r[0] = gf_mul(fb, g[0]);
    end
    for (int i = 0; i < 22; i++) par[i] = r[i];
  endtask

  // beats 0..nb-1; last_i on beat last_at (-1 = never)
  task automatic send_data(input bit gaps, input int nb, input int last_at);
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick;
      valid = 1'b1; start = (b == 0); last = (b == last_at);
      for (int j = 0; j < 8; j++) s_blk[j] = ext[8*b + j];
      if (b >= 1 && ((b == 65) == (b == last_at))) push_cw(b - 1);
      tick;
      idle_in;
    end
  endtask

  task automatic send_parity;
    pv = 1'b1;
    for (int i = 0; i < 22; i++) par_in[i] = par[i];
    push_cw(65); push_cw(66); push_cw(67);
    tick;
    idle_in;
  endtask

  // output monitor / scoreboard / serial remainder checker
  initial begin
    exp_t       e;
    logic [9:0] fb;
    logic [9:0] nz;
    forever begin
      @(negedge clk);
      cyc++;
      if (err) err_cnt++;
      if (cw_valid) begin
        vld_cnt++;
        if (cw_sop) begin
          sop_cnt++; sop_gap = cyc - eop_cyc; idx = 0;
          for (int i = 0; i < 22; i++) rem[i] = '0;
        end
        if (idx < 68) for (int j = 0; j < 8; j++) cap[idx][j] = cw_blk[j];
        idx++;
        chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          for (int j = 0; j < 8; j++) chk("beat_lane", 32'(cw_blk[j]), 32'(e.blk[j]));
          chk("sop", 32'(cw_sop), 32'(e.sop));
          chk("eop", 32'(cw_eop), 32'(e.eop));
        end
        for (int j = 0; j < 8; j++) begin
          fb = cw_blk[j] ^ rem[21];
          for (int i = 21; i > 0; i--) rem[i] = rem[i-1] ^ gf_mul(fb, g[i]);
          rem[0] = gf_mul(fb, g[0]);
        end
        if (cw_eop) begin
          eop_cnt++; eop_cyc = cyc;
          if (chk_en) begin
            nz = '0;
            for (int i = 0; i < 22; i++) nz = nz | rem[i];
            chk("remainder", 32'(nz), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] a;
    int v0, e0, n;
    // generator polynomial, roots alpha^0..alpha^21 over x^10+x^3+1
    for (int i = 0; i < 23; i++) g[i] = '0;
    g[0] = 10'd1; a = 10'd1;
    for (int i = 0; i < 22; i++) begin
      for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], a);
      g[0] = gf_mul(g[0], a);
      a = gf_mul(a, 10'd2);
    end
    for (int i = 0; i < 22; i++) rem[i] = '0;
    for (int j = 0; j < 8; j++) s_blk[j] = '0;
    for (int i = 0; i < 22; i++) par_in[i] = '0;
    idle_in;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(cw_valid), 32'd0);
    chk("rst_sop",   32'(cw_sop),   32'd0);
    chk("rst_eop",   32'(cw_eop),   32'd0);
    chk("rst_err",   32'(err),      32'd0);
    chk("rst_blk",   32'(cw_blk[3]), 32'd0);
    rst_n = 1'b1;
    tick;

    // two back-to-back frames: parity 1 cycle after last, restart 2 cycles after parity
    fill_a;
    send_data(1'b0, 66, 65);
    send_parity;
    tick;
    send_data(1'b0, 66, 65);
    send_parity;
    repeat (5) tick;
    chk("ab_valid_cnt", 32'(vld_cnt), 32'd136);
    chk("ab_sop_cnt",   32'(sop_cnt), 32'd2);
    chk("ab_eop_cnt",   32'(eop_cnt), 32'd2);
    chk("ab_sop_after_eop", 32'(sop_gap), 32'd1);
    chk("ab_err_cnt",   32'(err_cnt), 32'd0);
    for (int j = 0; j < 8; j++) begin
      chk("beat0",  32'(cap[0][j]),  32'(521 - j));
      chk("beat64", 32'(cap[64][j]), 32'(9 - j));
      chk("beat65", 32'(cap[65][j]), (j < 2) ? 32'(1 - j) : 32'(32'h315 - (j - 2)));
      chk("beat66", 32'(cap[66][j]), 32'(32'h30F - j));
      chk("beat67", 32'(cap[67][j]), 32'(32'h307 - j));
    end

    // same content with random valid gaps
    v0 = vld_cnt;
    send_data(1'b1, 66, 65);
    tick;
    send_parity;
    repeat (5) tick;
    chk("gap_valid_cnt", 32'(vld_cnt - v0), 32'd68);

    // three random encoded frames; every codeword must divide by g(x)
    chk_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_rand;
      send_data(1'b1, 66, 65);
      n = $urandom_range(0, 3);
      repeat (n) tick;
      send_parity;
      tick;
    end
    repeat (5) tick;
    chk_en = 1'b0;
    chk("rand_err_cnt", 32'(err_cnt), 32'd0);

    // start in T1: ignored, tail intact
    fill_a;
    e0 = eop_cnt;
    send_data(1'b0, 66, 65);
    send_parity;
    valid = 1'b1; start = 1'b1;
    for (int j = 0; j < 8; j++) s_blk[j] = ext[j];
    tick;
    idle_in;
    repeat (4) tick;
    chk("t1start_err", 32'(err_cnt), 32'd1);
    chk("t1start_eop", 32'(eop_cnt - e0), 32'd1);

    // last on beat 40: frame dropped, no eop
    e0 = eop_cnt;
    send_data(1'b0, 41, 40);
    repeat (3) tick;
    chk("last40_err", 32'(err_cnt), 32'd2);
    chk("last40_eop", 32'(eop_cnt - e0), 32'd0);

    // stray parity in IDLE, then a clean frame
    pv = 1'b1;
    tick;
    idle_in;
    repeat (2) tick;
    chk("straypar_err", 32'(err_cnt), 32'd3);
    e0 = eop_cnt;
    send_data(1'b0, 66, 65);
    send_parity;
    repeat (4) tick;
    chk("clean_eop", 32'(eop_cnt - e0), 32'd1);

    // reset at input beat 30, then a clean frame
    send_data(1'b0, 30, -1);
    tick;
    e0 = eop_cnt;
    rst_n = 1'b0;
    valid = 1'b1;
    for (int j = 0; j < 8; j++) s_blk[j] = ext[240 + j];
    #1;
    chk("midrst_valid", 32'(cw_valid), 32'd0);
    chk("midrst_blk",   32'(cw_blk[0]), 32'd0);
    chk("midrst_sop",   32'(cw_sop),    32'd0);
    tick;
    idle_in;
    rst_n = 1'b1;
    tick;
    chk("midrst_q_empty", 32'(q.size()), 32'd0);
    send_data(1'b0, 66, 65);
    send_parity;
    repeat (4) tick;
    chk("postrst_eop", 32'(eop_cnt - e0), 32'd1);

    n = 0;
    while (q.size() > 0 && n < 20) begin
      tick;
      n++;
    end
    chk("final_q_empty", 32'(q.size()), 32'd0);
    chk("final_err_cnt", 32'(err_cnt), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs544522_cw_assembler_lal8.md
Name: rs544522_cw_assembler_lal8

Overview:
- Downstream neighbour of the 8-lane RS(544,522) parity encoder.
- Consumes the same front-padded 8-lane message stream the encoder sees (6 leading zeros, 66 beats) plus the encoder's 22 parity symbols.
- Emits the systematic codeword as 68 full 8-symbol beats: 522 data symbols followed by 22 parity symbols, lane 0 = highest degree.
- Removes the 6-symbol front pad by one-beat realignment and splices parity into the tail.

Parameters:
- W, 10, symbol width.
- L, 8, lanes per beat (fixed; only 8 supported).
- K, 522, message symbols.
- R, 22, parity symbols.
- ZP, 6, front-pad zeros on the input stream.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  first input beat of a frame (qualified by valid_i).
- valid_i  in  1  input beat valid.
- last_i  in  1  final input beat (input beat 65).
- s_blk_i  in  L×W  unpacked [0:L-1]; lane j = extended position 8b+j; positions 0..5 are pad.
- parity_valid_i  in  1  encoder parity strobe.
- parity_i  in  R×W  unpacked [0:R-1]; parity_i[i] = coefficient of x^i.
- cw_valid_o  out  1  output beat valid.
- cw_sop_o  out  1  first codeword beat.
- cw_eop_o  out  1  beat 67.
- cw_blk_o  out  L×W  unpacked [0:L-1]; lane j of beat k = codeword coefficient x^(543-8k-j).
- err_o  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset: one clock; async active-low reset. All outputs 0, state IDLE, counters 0, holding registers 0. Reset mid-frame discards the frame; no eop is issued.
- Registers:
  - hold register: lanes 6,7 of the previous input beat.
  - parity register: R×W.
  - beat counter: 0..65.
- States and transitions:
  - IDLE → DATA on valid_i & start_i. Beat 0 is captured (count=1); no output is produced.
  - DATA: each valid_i beat b≥1 loads output beat b-1 = {hold[6], hold[7], s_blk_i[0..5]}, then refreshes hold. Output appears on the next cycle. sop is asserted with output beat 0.
  - DATA, last_i on beat 65 → WAIT_PAR.
  - WAIT_PAR: on parity_valid_i, capture parity and load output beat 65 = {hold[6], hold[7], p21..p16} → T1. Wait is unbounded.
  - T1: load beat 66 = p15..p8 → T2.
  - T2: load beat 67 = p7..p0 with eop → IDLE.
- Gaps: valid_i may drop mid-frame. Output beats stall correspondingly, and cw_valid_o is low in gap cycles. Outputs are registered; cw_* hold their last value but are qualified only by cw_valid_o.
- Latency:
  - Output beat k (k≤64) is valid one cycle after input beat k+1 is accepted.
  - Output beat 65 is valid one cycle after parity_valid_i.
  - Beats 66 and 67 follow on consecutive cycles.
- Frame spacing: start_i is legal in IDLE and T2. The earliest legal restart is 2 cycles after parity_valid_i; starting in T2 does not disturb beat 67.
- Errors (err_o pulses one cycle after the offending input):
  - start_i in DATA: partial frame dropped (no eop), new frame begins with this beat.
  - start_i in WAIT_PAR or T1: start ignored; current tail completes.
  - valid_i without start_i in IDLE: beat ignored.
  - last_i on beat ≠65, or no last_i on beat 65: frame dropped, → IDLE.
  - parity_valid_i outside WAIT_PAR: ignored.
- Simultaneous events: start_i and parity_valid_i in the same WAIT_PAR cycle → parity is taken and start is flagged as an error.

Test Plan:
- Single frame, data_k[i]=i, parity_i[i]=0x300+i:
  - beat0 = 521..514; beat64 = 9..2; beat65 = {1, 0, 0x315..0x310}; beat66 = 0x30F..0x308; beat67 = 0x307..0x300.
  - Exactly 68 valid beats; sop only on beat0; eop only on beat67.
- Parity 1 cycle after last, next start 2 cycles after parity: two frames are emitted intact with no err_o. The second sop immediately follows the first frame's eop.
- Random 1-3 cycle valid_i gaps inside a frame: output content is identical to the gapless case; cw_valid_o count = 68.
- Protocol errors, each producing one err_o pulse:
  - start_i in T1 → tail unaffected.
  - last_i on beat 40 → no eop, state IDLE.
  - Stray parity_valid_i in IDLE → ignored.
- rst_ni low at input beat 30 → outputs 0 immediately; the following clean frame is correct.
- Integration with encoder plus serial LFSR checker, 3 random frames: the 544 emitted symbols, fed lane 0 first, give a zero remainder.
